// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and types for the memory-access stage
package mem_access_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_SECOND
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Unlisted funct3 codes behave as full-word accesses.
    function automatic size_e decode_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: decode_size = SZ_B;
            F3_H, F3_HU: decode_size = SZ_H;
            default:     decode_size = SZ_W;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [2:0] f3);
        is_signed_load = (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/mem_access_stage_data_memory.sv
// rtl/mem_access_stage_data_memory.sv - word-organised data memory with byte-lane writes and async read
module mem_access_stage_data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I M-stage loads/stores into W-stage bundle; MISALIGNED_SPLIT_EN enables two-beat crossing accesses
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int DEPTH_WORDS            = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              RegWriteM,
    input  logic [1:0]                        ResultsrcM,
    input  logic                              MemWriteM,
    input  logic [2:0]                        Funct3M,
    input  logic [DATA_WIDTH-1:0]             ALUResultM,
    input  logic [DATA_WIDTH-1:0]             WriteDataM,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic                              StallM,
    output logic                              RegWriteW,
    output logic [1:0]                        ResultsrcW,
    output logic [DATA_WIDTH-1:0]             ALUResultW,
    output logic [DATA_WIDTH-1:0]             ReadDataW,
    output logic [DATA_WIDTH-1:0]             PCPlus4W,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0]             ResultW
);

    localparam int AW = $clog2(DEPTH_WORDS);

    size_e                       size;
    logic                        sext;
    logic [1:0]                  offset;
    logic                        is_load;
    logic                        is_store;
    logic                        is_access;
    logic                        crossing;
    logic                        second_beat;
    logic                        split_first;
    logic [7:0]                  size_lanes;
    logic [7:0]                  lane_mask;
    logic [AW-1:0]               word_idx;
    logic [AW-1:0]               mem_addr;
    logic [3:0]                  mem_we;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       mem_rdata;
    logic [2*DATA_WIDTH-1:0]     store_sh;
    logic [2*DATA_WIDTH-1:0]     load_cat;
    logic [DATA_WIDTH-1:0]       load_sh;
    logic [DATA_WIDTH-1:0]       load_ext;

    logic                              reg_write_w_q, reg_write_w_d;
    logic [1:0]                        resultsrc_w_q, resultsrc_w_d;
    logic [DATA_WIDTH-1:0]             alu_result_w_q, alu_result_w_d;
    logic [DATA_WIDTH-1:0]             read_data_w_q, read_data_w_d;
    logic [DATA_WIDTH-1:0]             pc_plus4_w_q, pc_plus4_w_d;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w_q, rd_w_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUResultM[DATA_WIDTH-1:AW+2];

`ifdef MISALIGNED_SPLIT_EN
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    assign second_beat = (state_q == ST_SECOND);
`else
    assign second_beat = 1'b0;
`endif

    always_comb begin
        size      = decode_size(Funct3M);
        sext      = is_signed_load(Funct3M);
        is_store  = MemWriteM;
        is_load   = (ResultsrcM == RES_LOAD) && !MemWriteM;
        is_access = is_load || is_store;

`ifdef MISALIGNED_SPLIT_EN
        offset = ALUResultM[1:0];
`else
        // Without splitting, snap to natural alignment so nothing crosses a word.
        case (size)
            SZ_H:    offset = {ALUResultM[1], 1'b0};
            SZ_W:    offset = 2'b00;
            default: offset = ALUResultM[1:0];
        endcase
`endif

        case (size)
            SZ_B:    size_lanes = 8'h01;
            SZ_H:    size_lanes = 8'h03;
            default: size_lanes = 8'h0F;
        endcase

        // Lanes [3:0] belong to word N, lanes [7:4] spill into word N+1.
        lane_mask   = size_lanes << offset;
        crossing    = is_access && (lane_mask[7:4] != 4'b0000);
        split_first = crossing && !second_beat;

        word_idx = ALUResultM[AW+1:2];
        mem_addr = second_beat ? (word_idx + AW'(1)) : word_idx;

        store_sh  = {{DATA_WIDTH{1'b0}}, WriteDataM} << {offset, 3'b000};
        mem_wdata = second_beat ? store_sh[2*DATA_WIDTH-1:DATA_WIDTH] : store_sh[DATA_WIDTH-1:0];
        // Reset abandons any pending second beat, including its store lanes.
        mem_we    = 4'b0000;
        if (is_store && !rst) begin
            mem_we = second_beat ? lane_mask[7:4] : lane_mask[3:0];
        end

`ifdef MISALIGNED_SPLIT_EN
        load_cat = second_beat ? {mem_rdata, hold_q} : {{DATA_WIDTH{1'b0}}, mem_rdata};
`else
        load_cat = {{DATA_WIDTH{1'b0}}, mem_rdata};
`endif
        load_sh = DATA_WIDTH'(load_cat >> {offset, 3'b000});

        case (size)
            SZ_B:    load_ext = sext ? {{24{load_sh[7]}}, load_sh[7:0]}   : {24'b0, load_sh[7:0]};
            SZ_H:    load_ext = sext ? {{16{load_sh[15]}}, load_sh[15:0]} : {16'b0, load_sh[15:0]};
            default: load_ext = load_sh;
        endcase
    end

    mem_access_stage_data_memory #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_WIDTH  (AW)
    ) u_data_memory (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

`ifdef MISALIGNED_SPLIT_EN
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (crossing) begin
                    state_d = ST_SECOND;
                    if (is_load) begin
                        hold_d = mem_rdata;
                    end
                end
            end
            ST_SECOND: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign StallM = (state_q == ST_IDLE) && crossing;
`else
    assign StallM = 1'b0;
`endif

    always_comb begin
        reg_write_w_d  = RegWriteM;
        resultsrc_w_d  = ResultsrcM;
        alu_result_w_d = ALUResultM;
        read_data_w_d  = is_load ? load_ext : '0;
        pc_plus4_w_d   = PCPlus4M;
        rd_w_d         = RdM;
        // First beat of a split hands a bubble to W.
        if (split_first) begin
            reg_write_w_d  = 1'b0;
            resultsrc_w_d  = 2'b00;
            alu_result_w_d = '0;
            read_data_w_d  = '0;
            pc_plus4_w_d   = '0;
            rd_w_d         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_w_q  <= 1'b0;
            resultsrc_w_q  <= 2'b00;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
            pc_plus4_w_q   <= '0;
            rd_w_q         <= '0;
        end else begin
            reg_write_w_q  <= reg_write_w_d;
            resultsrc_w_q  <= resultsrc_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            rd_w_q         <= rd_w_d;
        end
    end

    assign RegWriteW  = reg_write_w_q;
    assign ResultsrcW = resultsrc_w_q;
    assign ALUResultW = alu_result_w_q;
    assign ReadDataW  = read_data_w_q;
    assign PCPlus4W   = pc_plus4_w_q;
    assign RdW        = rd_w_q;

    always_comb begin
        case (resultsrc_w_q)
            RES_LOAD: ResultW = read_data_w_q;
            RES_PC4:  ResultW = pc_plus4_w_q;
            default:  ResultW = alu_result_w_q;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultsrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultsrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultsrcM (ResultsrcM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultsrcW (ResultsrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .ResultW    (ResultW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4);
        RegWriteM  = rw;
        ResultsrcM = rs;
        MemWriteM  = mw;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        RdM        = rd;
        PCPlus4M   = pc4;
    endtask

    task automatic store1(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        set_op(1'b0, 2'b00, 1'b1, f3, addr, wd, 5'd0, 32'h0);
        tick();
    endtask

    task automatic load1(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
        set_op(1'b1, 2'b01, 1'b0, f3, addr, 32'h0, 5'd5, 32'h0);
        #1;
        check({tag, "_stall"}, {31'b0, StallM}, 32'h0);
        tick();
        check(tag, ReadDataW, exp);
    endtask

`ifdef MISALIGNED_SPLIT_EN
    task automatic load2(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
        set_op(1'b1, 2'b01, 1'b0, f3, addr, 32'h0, 5'd6, 32'h0);
        #1;
        check({tag, "_stall"}, {31'b0, StallM}, 32'h1);
        tick();
        check({tag, "_bubble"}, {31'b0, RegWriteW}, 32'h0);
        check({tag, "_beat1_data"}, ReadDataW, 32'h0);
        tick();
        check(tag, ReadDataW, exp);
        check({tag, "_result"}, ResultW, exp);
    endtask
`endif

    initial begin
        set_op(1'b1, 2'b10, 1'b0, 3'b010, 32'h55, 32'h66, 5'd7, 32'h77);
        rst = 1'b1;
        tick();
        tick();
        check("rst_regwrite", {31'b0, RegWriteW}, 32'h0);
        check("rst_resultsrc", {30'b0, ResultsrcW}, 32'h0);
        check("rst_alu", ALUResultW, 32'h0);
        check("rst_rdata", ReadDataW, 32'h0);
        check("rst_pc4", PCPlus4W, 32'h0);
        check("rst_rd", {27'b0, RdW}, 32'h0);
        check("rst_result", ResultW, 32'h0);
        check("rst_stall", {31'b0, StallM}, 32'h0);
        rst = 1'b0;

        store1(3'b010, 32'h100, 32'hDEADBEEF);
        load1("lw_100", 3'b010, 32'h100, 32'hDEADBEEF);
        check("lw_rd", {27'b0, RdW}, 32'd5);
        check("lw_result", ResultW, 32'hDEADBEEF);

        store1(3'b000, 32'h101, 32'h12345680);
        load1("lw_after_sb", 3'b010, 32'h100, 32'hDEAD80EF);
        load1("lb_101", 3'b000, 32'h101, 32'hFFFFFF80);
        load1("lbu_101", 3'b100, 32'h101, 32'h00000080);
        load1("lb_100", 3'b000, 32'h100, 32'hFFFFFFEF);
        load1("lbu_103", 3'b100, 32'h103, 32'h000000DE);
        load1("lh_102", 3'b001, 32'h102, 32'hFFFFDEAD);
        load1("lhu_102", 3'b101, 32'h102, 32'h0000DEAD);
        load1("lh_100", 3'b001, 32'h100, 32'hFFFF80EF);
        load1("f3_011_as_w", 3'b011, 32'h100, 32'hDEAD80EF);
        load1("alias_1100", 3'b010, 32'h1100, 32'hDEAD80EF);

        set_op(1'b1, 2'b01, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 5'd9, 32'h0);
        tick();
        check("st_prio_resultsrc", {30'b0, ResultsrcW}, 32'h1);
        check("st_prio_rd", {27'b0, RdW}, 32'd9);
        load1("st_prio_lw", 3'b010, 32'h200, 32'hCAFEF00D);

        store1(3'b001, 32'h202, 32'h00001234);
        load1("lw_after_sh", 3'b010, 32'h200, 32'h1234F00D);
        load1("lh_200", 3'b001, 32'h200, 32'hFFFFF00D);
        load1("lhu_202", 3'b101, 32'h202, 32'h00001234);

        set_op(1'b1, 2'b00, 1'b0, 3'b010, 32'h103, 32'h0, 5'd4, 32'h44);
        #1;
        check("alu_misaligned_stall", {31'b0, StallM}, 32'h0);
        tick();
        check("alu_result", ResultW, 32'h103);
        check("alu_regwrite", {31'b0, RegWriteW}, 32'h1);
        check("alu_rd", {27'b0, RdW}, 32'd4);
        set_op(1'b1, 2'b10, 1'b0, 3'b010, 32'h103, 32'h0, 5'd4, 32'h44);
        tick();
        check("pc4_result", ResultW, 32'h44);
        set_op(1'b1, 2'b11, 1'b0, 3'b010, 32'h103, 32'h0, 5'd4, 32'h44);
        tick();
        check("src11_result", ResultW, 32'h103);

`ifndef MISALIGNED_SPLIT_EN
        load1("lh_103_aligned", 3'b001, 32'h103, 32'hFFFFDEAD);
        set_op(1'b0, 2'b00, 1'b1, 3'b010, 32'h102, 32'h11223344, 5'd0, 32'h0);
        #1;
        check("sw_102_stall", {31'b0, StallM}, 32'h0);
        tick();
        load1("lw_100_after_sw102", 3'b010, 32'h100, 32'h11223344);
        load1("lw_101_aligned", 3'b010, 32'h101, 32'h11223344);
`else
        store1(3'b010, 32'h104, 32'hAAAAAAAA);
        set_op(1'b1, 2'b00, 1'b1, 3'b010, 32'h102, 32'h11223344, 5'd3, 32'h8);
        #1;
        check("ssw_stall", {31'b0, StallM}, 32'h1);
        tick();
        check("ssw_bubble_rw", {31'b0, RegWriteW}, 32'h0);
        check("ssw_bubble_alu", ALUResultW, 32'h0);
        check("ssw_second_stall", {31'b0, StallM}, 32'h0);
        tick();
        check("ssw_done_rw", {31'b0, RegWriteW}, 32'h1);
        check("ssw_done_alu", ALUResultW, 32'h102);
        load1("ssw_word_n", 3'b010, 32'h100, 32'h334480EF);
        load1("ssw_word_n1", 3'b010, 32'h104, 32'hAAAA1122);
        load2("slw_102", 3'b010, 32'h102, 32'h11223344);

        store1(3'b000, 32'h103, 32'h000000AA);
        store1(3'b000, 32'h104, 32'h000000FF);
        load2("slh_103", 3'b001, 32'h103, 32'hFFFFFFAA);
        load2("slhu_103", 3'b101, 32'h103, 32'h0000FFAA);
        load1("lh_102_nocross", 3'b001, 32'h102, 32'hFFFFAA44);

        store1(3'b010, 32'hFFC, 32'h44332211);
        store1(3'b010, 32'h000, 32'h88776655);
        load2("wrap_lw_ffd", 3'b010, 32'hFFD, 32'h55443322);

        store1(3'b010, 32'h300, 32'h0);
        store1(3'b010, 32'h304, 32'h0);
        set_op(1'b1, 2'b00, 1'b1, 3'b010, 32'h301, 32'hA1B2C3D4, 5'd3, 32'h10);
        #1;
        check("rsw_stall", {31'b0, StallM}, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        check("rsw_rw", {31'b0, RegWriteW}, 32'h0);
        check("rsw_alu", ALUResultW, 32'h0);
        check("rsw_result", ResultW, 32'h0);
        check("rsw_idle_stall", {31'b0, StallM}, 32'h1);
        rst = 1'b0;
        load1("rsw_word_n", 3'b010, 32'h300, 32'hB2C3D400);
        load1("rsw_word_n1", 3'b010, 32'h304, 32'h00000000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
